clint_ctrl: RTL
===============

CLINT_CTRL -- requirements
Module: clint_ctrl

Interface
REQ-001 SHALL have one parameter: EXT_INT_CAUSE, default 32'h8000000B, mcause value for an external interrupt.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 inst_i  in  32  instruction currently in execute.
REQ-006 inst_addr_i  in  32  PC of inst_i.
REQ-007 jump_flag_i / jump_addr_i  in  1/32  execute redirect and its target.
REQ-008 int_flag_i  in  1  external interrupt request, level.
REQ-009 global_int_en_i  in  1  mstatus.MIE from the CSR file.
REQ-010 csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  32 each  live CSR values.
REQ-011 we_o / waddr_o / data_o  out  1/32/32  CSR write port into the CSR file; waddr_o[11:0] holds the CSR number, upper bits 0.
REQ-012 hold_flag_o  out  1  stall request to the pipeline.
REQ-013 int_assert_o / int_addr_o  out  1/32  one-cycle PC redirect and its target.

Function
REQ-014 Decode: ecall = 32'h00000073, cause 11; ebreak = 32'h00100073, cause 3; mret = 32'h30200073.
REQ-015 States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, ASSERT.
REQ-016 In IDLE, an ecall or ebreak SHALL capture mepc = inst_addr_i and the cause, then enter W_MEPC.
REQ-017 In IDLE, an async event (int_flag_i & global_int_en_i, no sync event present) SHALL capture mepc = jump_flag_i ? jump_addr_i : inst_addr_i and cause = EXT_INT_CAUSE, then enter W_MEPC.
REQ-018 In IDLE, mret SHALL enter W_MRET.
REQ-019 Priority SHALL be sync exception > mret > async interrupt; all events SHALL be ignored outside IDLE.
REQ-020 Trap sequence (event in cycle N) SHALL be: N+1 W_MEPC writes 0x341 = captured mepc; N+2 W_MCAUSE writes 0x342 = cause; N+3 W_MSTATUS writes 0x300 = csr_mstatus_i with bit7 <= bit3 and bit3 <= 0; N+4 ASSERT drives int_assert_o=1, int_addr_o=csr_mtvec_i; N+5 IDLE.
REQ-021 mret sequence (event in cycle N) SHALL be: N+1 W_MRET writes 0x300 = csr_mstatus_i with bit3 <= bit7 and bit7 <= 1; N+2 ASSERT with int_addr_o = csr_mepc_i; N+3 IDLE.
REQ-022 we_o SHALL be 1 only in the W_* states; waddr_o/data_o SHALL be 0 when we_o=0.
REQ-023 int_assert_o SHALL be high for exactly one cycle per event; int_addr_o SHALL be 0 otherwise.
REQ-024 hold_flag_o SHALL be combinationally high in the detection cycle and in every non-IDLE state except the final ASSERT cycle.
REQ-025 The async event SHALL be level-sampled; an interrupt still asserted after return SHALL retrigger only once MIE is 1 again.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, clear the captured registers, and drive all outputs to 0, including mid-sequence; a partial CSR sequence SHALL be abandoned with no further writes.

Configuration
REQ-027 With CLINT_ASYNC_INT_EN defined, REQ-017 and REQ-025 apply; without it, int_flag_i SHALL be ignored, the async path SHALL be absent, and the sync and mret behaviour SHALL be unchanged.

Verification
REQ-028 ecall at PC 0x100, mtvec 0x80, mstatus 0x8 -> writes mepc=0x100, mcause=11, mstatus=0x80; int_assert at N+4 with addr 0x80.
REQ-029 mret with mstatus 0x80, mepc 0x104 -> mstatus write 0x88 at N+1; int_assert at N+2 with addr 0x104.
REQ-030 int_flag_i=1, MIE=1, jump_flag_i=1, jump_addr 0x200 -> mepc=0x200, mcause=0x8000000B; with MIE=0 -> no activity.
REQ-031 ebreak and int_flag_i in the same cycle -> mcause=3, one sequence only; the interrupt is not taken while MIE=0.
REQ-032 rst pulsed at N+2 of a trap -> no mstatus write, no int_assert, all outputs 0.
REQ-033 Build without CLINT_ASYNC_INT_EN, int_flag_i=1, MIE=1 -> no writes, hold_flag_o stays 0.

Source files
------------

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: sequences the mepc/mcause/mstatus CSR writes for traps and mret, then redirects the PC.
// Optional macro CLINT_ASYNC_INT_EN enables the external (async) interrupt path; it is absent by default.
module clint_ctrl #(
  parameter logic [31:0] EXT_INT_CAUSE = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CSR_AW   = 12;

  localparam logic [XLEN-1:0]   INST_ECALL  = 32'h00000073;
  localparam logic [XLEN-1:0]   INST_EBREAK = 32'h00100073;
  localparam logic [XLEN-1:0]   INST_MRET   = 32'h30200073;
  localparam logic [XLEN-1:0]   CAUSE_ECALL  = 32'd11;
  localparam logic [XLEN-1:0]   CAUSE_EBREAK = 32'd3;
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] cause_q;

  logic            is_ecall;
  logic            is_ebreak;
  logic            is_mret;
  logic            sync_evt;
  logic            async_evt;
  logic [XLEN-1:0] async_mepc;
  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] mret_mstatus;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign sync_evt  = is_ecall | is_ebreak;

`ifdef CLINT_ASYNC_INT_EN
  // Level-sensitive request, lowest priority behind sync exceptions and mret.
  assign async_evt  = int_flag_i & global_int_en_i & ~sync_evt & ~is_mret;
  assign async_mepc = jump_flag_i ? jump_addr_i : inst_addr_i;
`else
  logic unused_async;
  assign unused_async = ^{int_flag_i, global_int_en_i, jump_flag_i, jump_addr_i};
  assign async_evt    = 1'b0;
  assign async_mepc   = '0;
`endif

  // Trap entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
  assign trap_mstatus = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
  assign mret_mstatus = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};

  // Stall in the detection cycle and while CSR writes are in flight.
  assign hold_flag_o = ((state == S_IDLE) & (sync_evt | is_mret | async_evt)) |
                       (state == S_W_MEPC) | (state == S_W_MCAUSE) |
                       (state == S_W_MSTATUS) | (state == S_W_MRET);

  // Outputs are registered against the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cause_q      <= '0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (state)
        S_IDLE: begin
          if (sync_evt) begin
            state   <= S_W_MEPC;
            cause_q <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
            we_o    <= 1'b1;
            waddr_o <= XLEN'(CSR_MEPC);
            data_o  <= inst_addr_i;
          end else if (is_mret) begin
            state   <= S_W_MRET;
            we_o    <= 1'b1;
            waddr_o <= XLEN'(CSR_MSTATUS);
            data_o  <= mret_mstatus;
          end else if (async_evt) begin
            state   <= S_W_MEPC;
            cause_q <= EXT_INT_CAUSE;
            we_o    <= 1'b1;
            waddr_o <= XLEN'(CSR_MEPC);
            data_o  <= async_mepc;
          end
        end
        S_W_MEPC: begin
          state   <= S_W_MCAUSE;
          we_o    <= 1'b1;
          waddr_o <= XLEN'(CSR_MCAUSE);
          data_o  <= cause_q;
        end
        S_W_MCAUSE: begin
          state   <= S_W_MSTATUS;
          we_o    <= 1'b1;
          waddr_o <= XLEN'(CSR_MSTATUS);
          data_o  <= trap_mstatus;
        end
        S_W_MSTATUS: begin
          state        <= S_ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mtvec_i;
        end
        S_W_MRET: begin
          state        <= S_ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        S_ASSERT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
